// File: rtl/io_input_unit_if.sv
// Processor IO read bus between the MIPS core (master) and the switch input unit (slave).
interface io_input_unit_if;
  logic [3:0]  IOAddr;
  logic        IOReadEn;
  logic [31:0] IOReadData;

  modport master (output IOAddr, output IOReadEn, input IOReadData);
  modport slave  (input IOAddr, input IOReadEn, output IOReadData);
endinterface

// File: rtl/io_input_unit.sv
// Switch input port: 2-flop sync, per-bit debounce, rising-edge event latch with
// clear-on-read, debounced-transition counter and a combinational IO read mux.
module io_input_unit #(
  parameter int NSW        = 4,
  parameter int DEB_CYCLES = 50000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NSW-1:0]    SW,
  io_input_unit_if.slave    io_bus
);

  localparam logic [19:0] DEB_MAX = 20'(DEB_CYCLES - 1);

  logic [NSW-1:0] r_sync1;
  logic [NSW-1:0] r_sync2;
  logic [NSW-1:0] r_stable;
  logic [NSW-1:0] r_evt;
  logic [19:0]    r_cnt [NSW];
  logic [15:0]    r_chg;

  logic [NSW-1:0] w_stable_nxt;
  logic [19:0]    w_cnt_nxt [NSW];
  logic [NSW-1:0] w_rise;
  logic [NSW-1:0] w_toggle;
  logic [4:0]     w_nchg;
  logic           w_clr;
  logic [NSW-1:0] w_evt_nxt;
  logic [31:0]    w_rdata;

  // Per-bit debounce decision: restart on agreement, accept after a full run of disagreement.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < NSW; i++) begin
      w_cnt_nxt[i] = 20'd0;
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_nxt[i] = 20'd0;
      end else if (r_cnt[i] == DEB_MAX) begin
        w_stable_nxt[i] = r_sync2[i];
        w_cnt_nxt[i]    = 20'd0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 20'd1;
      end
    end
  end

  // Edge detection, transition count and event latch with set-over-clear priority.
  always_comb begin
    w_rise   = w_stable_nxt & ~r_stable;
    w_toggle = w_stable_nxt ^ r_stable;
    w_nchg   = 5'd0;
    for (int i = 0; i < NSW; i++) begin
      w_nchg = w_nchg + {4'd0, w_toggle[i]};
    end
    w_clr = io_bus.IOReadEn && (io_bus.IOAddr == 4'h5);
    if (w_clr) begin
      w_evt_nxt = w_rise;
    end else begin
      w_evt_nxt = r_evt | w_rise;
    end
  end

  // State registers; everything returns to zero on reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_evt    <= '0;
      r_chg    <= 16'd0;
      for (int i = 0; i < NSW; i++) begin
        r_cnt[i] <= 20'd0;
      end
    end else begin
      r_sync1  <= SW;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_nxt;
      r_evt    <= w_evt_nxt;
      r_chg    <= r_chg + {11'd0, w_nchg};
      for (int i = 0; i < NSW; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Zero-latency read mux; unmapped addresses read as zero.
  always_comb begin
    w_rdata = 32'h0;
    case (io_bus.IOAddr)
      4'h4:    w_rdata = 32'(r_stable);
      4'h5:    w_rdata = 32'(r_evt);
      4'h6:    w_rdata = {16'h0, r_chg};
      4'h7:    w_rdata = {31'h0, |r_evt};
      default: w_rdata = 32'h0;
    endcase
  end

  assign io_bus.IOReadData = w_rdata;

endmodule

// File: tb/tb_io_input_unit.sv
// Randomized/directed bench for io_input_unit against an edge-history reference model.
module tb_io_input_unit;

  localparam int NSW = 4;
  localparam int DEB = 4;

  logic           CLK = 1'b0;
  logic           RESET = 1'b0;
  logic [NSW-1:0] SW = '0;

  io_input_unit_if bus ();

  io_input_unit #(.NSW(NSW), .DEB_CYCLES(DEB)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .SW     (SW),
    .io_bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted level flips once the synchronised level has disagreed
  // for the last DEB edges, counted only since the previous acceptance.
  logic [NSW-1:0] m_stable;
  logic [NSW-1:0] m_evt;
  logic [15:0]    m_chg;
  logic [NSW-1:0] m_dq [$];
  logic [NSW-1:0] m_hist [$];
  int             m_edge;
  int             m_last [NSW];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 32'h%08h expected 32'h%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stable = '0;
    m_evt    = '0;
    m_chg    = 16'd0;
    m_dq.delete();
    m_dq.push_back('0);
    m_dq.push_back('0);
    m_hist.delete();
    m_edge = 0;
    for (int i = 0; i < NSW; i++) m_last[i] = 0;
  endtask

  task automatic model_edge(input logic [NSW-1:0] sw, input logic clr);
    logic [NSW-1:0] d;
    logic [NSW-1:0] nxt;
    bit             all_diff;
    int             n;
    d = m_dq.pop_front();
    m_dq.push_back(sw);
    m_hist.push_back(d);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    m_edge++;
    nxt = m_stable;
    for (int i = 0; i < NSW; i++) begin
      if ((m_edge - m_last[i]) >= DEB && m_hist.size() == DEB) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          nxt[i]    = ~m_stable[i];
          m_last[i] = m_edge;
        end
      end
    end
    n = 0;
    for (int i = 0; i < NSW; i++) if (nxt[i] != m_stable[i]) n++;
    m_evt    = (clr ? '0 : m_evt) | (nxt & ~m_stable);
    m_chg    = m_chg + 16'(n);
    m_stable = nxt;
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    case (a)
      4'h4:    return 32'(m_stable);
      4'h5:    return 32'(m_evt);
      4'h6:    return {16'h0, m_chg};
      4'h7:    return {31'h0, |m_evt};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: model follows the DUT edge, then inputs may change at the falling edge.
  task automatic cyc();
    @(posedge CLK);
    if (RESET) model_reset();
    else model_edge(SW, bus.IOReadEn && (bus.IOAddr == 4'h5));
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    bus.IOAddr = a;
    #1;
    v = bus.IOReadData;
  endtask

  task automatic check_reads(input string tag);
    logic [31:0] v;
    for (int a = 4; a < 8; a++) begin
      rd(4'(a), v);
      chk_eq($sformatf("%s_a%0d", tag, a), v, exp_read(4'(a)));
    end
    bus.IOAddr = 4'h0;
  endtask

  task automatic strobe_clear(input string tag, input logic [3:0] a);
    logic [31:0] v;
    bus.IOReadEn = 1'b1;
    rd(a, v);
    chk_eq({tag, "_strobe"}, v, exp_read(a));
    cyc();
    bus.IOReadEn = 1'b0;
    bus.IOAddr   = 4'h0;
  endtask

  initial begin
    logic [31:0] v;
    int          guard;
    bus.IOAddr   = 4'h0;
    bus.IOReadEn = 1'b0;
    model_reset();

    // Reset with switches high: everything reads zero.
    @(negedge CLK);
    SW    = 4'hF;
    RESET = 1'b1;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      chk_eq($sformatf("rst_a%0d", a), v, 32'h0);
    end
    bus.IOAddr = 4'h0;
    @(negedge CLK);
    run(2);
    RESET = 1'b0;
    run(5);
    rd(4'h4, v); chk_eq("rst_lat5", v, 32'h0);
    run(1);
    rd(4'h4, v); chk_eq("rst_stable", v, 32'hF);
    rd(4'h5, v); chk_eq("rst_evt", v, 32'hF);
    rd(4'h6, v); chk_eq("rst_chg", v, 32'h4);
    rd(4'h7, v); chk_eq("rst_any", v, 32'h1);
    bus.IOAddr = 4'h0;
    strobe_clear("clrA", 4'h5);
    check_reads("clrA_after");

    // All switches fall: no events, four transitions.
    SW = 4'h0;
    run(8);
    check_reads("fall");

    // Glitch rejection then exact 4-cycle acceptance.
    SW = 4'h1; run(3); SW = 4'h0; run(8);
    rd(4'h4, v); chk_eq("glitch_stable", v, 32'h0);
    rd(4'h6, v); chk_eq("glitch_chg", v, 32'h8);
    SW = 4'h1; run(4); SW = 4'h0; run(1);
    rd(4'h4, v); chk_eq("pulse_edge5", v, 32'h0);
    run(1);
    rd(4'h4, v); chk_eq("pulse_edge6", v, 32'h1);
    check_reads("pulse");
    run(8);

    // Clear-on-read with evt = 3, and a strobe at another address leaves it alone.
    SW = 4'h2; run(8);
    rd(4'h5, v); chk_eq("evt3", v, 32'h3);
    strobe_clear("noclr", 4'h4);
    rd(4'h5, v); chk_eq("noclr_evt", v, 32'h3);
    strobe_clear("clrB", 4'h5);
    rd(4'h5, v); chk_eq("clrB_evt", v, 32'h0);
    rd(4'h7, v); chk_eq("clrB_any", v, 32'h0);

    // Set wins over a coinciding clear.
    SW = 4'h3; run(8);
    rd(4'h5, v); chk_eq("sw_evt1", v, 32'h1);
    SW = 4'h7; run(5);
    strobe_clear("setwin", 4'h5);
    rd(4'h5, v); chk_eq("setwin_evt", v, 32'h4);
    rd(4'h6, v); chk_eq("setwin_chg", v, 32'hD);
    check_reads("setwin");

    // Drive the transition counter up to 16'hFFFE, then wrap with a 3-bit change.
    guard = 0;
    while (m_chg < 16'hFFE0 && guard < 20000) begin
      SW = ~SW;
      run(4);
      guard++;
      if (guard % 2048 == 0) check_reads("wrap_prog");
    end
    run(8);
    guard = 0;
    while (m_chg != 16'hFFFE && guard < 64) begin
      SW = SW ^ 4'h8;
      run(8);
      guard++;
    end
    check_reads("wrap_pre");
    rd(4'h6, v); chk_eq("wrap_fffe", v, 32'hFFFE);
    SW = SW ^ 4'h7;
    run(8);
    rd(4'h6, v); chk_eq("wrap_0001", v, 32'h1);

    // Reset in the middle of a debounce discards the partial count.
    SW = 4'h0; run(8);
    SW = 4'h2; run(3);
    RESET = 1'b1;
    model_reset();
    check_reads("midrst_in");
    run(1);
    RESET = 1'b0;
    run(5);
    rd(4'h4, v); chk_eq("midrst_lat5", v, 32'h0);
    run(1);
    rd(4'h4, v); chk_eq("midrst_stable", v, 32'h2);
    rd(4'h5, v); chk_eq("midrst_evt", v, 32'h2);
    rd(4'h6, v); chk_eq("midrst_chg", v, 32'h1);

    // Random switch activity, strobes and addresses against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) SW = 4'($urandom);
      bus.IOReadEn = ($urandom_range(0, 3) == 0);
      rd(4'($urandom), v);
      chk_eq("rnd", v, exp_read(bus.IOAddr));
      cyc();
    end
    bus.IOReadEn = 1'b0;
    check_reads("end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
